// File: rtl/pic_ack_sequencer.sv
// 8259A-style acknowledge sequencer: drives INT, runs the two-pulse INTA handshake,
// owns the In-Service Register and executes EOI commands from OCW2.
module pic_ack_sequencer #(
    parameter logic [2:0] SPURIOUS_INDEX = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_request,
    input  logic [2:0] serviced_interrupt_index,
    input  logic [2:0] zero_level_priority_bit,
    input  logic       inta_n,
    input  logic [4:0] icw2_vector_base,
    input  logic       aeoi,
    input  logic [7:0] ocw2,
    input  logic       ocw2_write,
    output logic       int_out,
    output logic       int_request_ack,
    output logic       freezing,
    output logic [7:0] isr_reg,
    output logic       irr_clear,
    output logic [2:0] irr_clear_index,
    output logic [2:0] reseted_isr_index,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PENDING = 3'd1;
    localparam logic [2:0] S_ACK1    = 3'd2;
    localparam logic [2:0] S_WAIT2   = 3'd3;
    localparam logic [2:0] S_ACK2    = 3'd4;

    logic [2:0] state_q, state_d;
    logic       inta_hist_q;
    logic       int_out_q, int_out_d;
    logic       ack_q, ack_d;
    logic       freezing_q, freezing_d;
    logic [7:0] isr_q, isr_d;
    logic       irr_clear_q, irr_clear_d;
    logic [2:0] irr_clear_index_q, irr_clear_index_d;
    logic [2:0] reseted_q, reseted_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_en_q, data_out_en_d;
    logic [2:0] cur_idx_q, cur_idx_d;
    logic       spurious_q, spurious_d;

    logic       inta_fall, inta_rise;
    logic [7:0] set_mask, aeoi_mask, eoi_clr;
    logic       aeoi_hit, eoi_hit;
    logic [2:0] eoi_idx, scan_idx;

    assign inta_fall = inta_hist_q & ~inta_n;
    assign inta_rise = ~inta_hist_q & inta_n;

    // EOI decode works on the ISR as it stood before this cycle's set.
    always_comb begin
        eoi_clr  = 8'd0;
        eoi_hit  = 1'b0;
        eoi_idx  = 3'd0;
        scan_idx = 3'd0;
        if (ocw2_write) begin
            case (ocw2[7:5])
                3'b001, 3'b101: begin
                    for (int i = 0; i < 8; i++) begin
                        scan_idx = zero_level_priority_bit + 3'(i);
                        if (!eoi_hit && isr_q[scan_idx]) begin
                            eoi_hit = 1'b1;
                            eoi_idx = scan_idx;
                            eoi_clr = 8'd1 << scan_idx;
                        end
                    end
                end
                3'b011: begin
                    eoi_hit = 1'b1;
                    eoi_idx = ocw2[2:0];
                    eoi_clr = 8'd1 << ocw2[2:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d           = state_q;
        int_out_d         = int_out_q;
        ack_d             = ack_q;
        freezing_d        = freezing_q;
        irr_clear_d       = 1'b0;
        irr_clear_index_d = irr_clear_index_q;
        data_out_d        = data_out_q;
        data_out_en_d     = data_out_en_q;
        cur_idx_d         = cur_idx_q;
        spurious_d        = spurious_q;
        set_mask          = 8'd0;
        aeoi_hit          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (int_request) begin
                    int_out_d = 1'b1;
                    state_d   = S_PENDING;
                end
            end
            S_PENDING: begin
                if (inta_fall) begin
                    state_d    = S_ACK1;
                    freezing_d = 1'b1;
                    if (int_request) begin
                        cur_idx_d         = serviced_interrupt_index;
                        spurious_d        = 1'b0;
                        set_mask          = 8'd1 << serviced_interrupt_index;
                        irr_clear_d       = 1'b1;
                        irr_clear_index_d = serviced_interrupt_index;
                        ack_d             = ~ack_q;
                    end else begin
                        cur_idx_d  = SPURIOUS_INDEX;
                        spurious_d = 1'b1;
                    end
                end
            end
            S_ACK1: begin
                if (inta_rise) begin
                    int_out_d = 1'b0;
                    state_d   = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (inta_fall) begin
                    data_out_d    = {icw2_vector_base, cur_idx_q};
                    data_out_en_d = 1'b1;
                    state_d       = S_ACK2;
                end
            end
            S_ACK2: begin
                if (inta_rise) begin
                    data_out_en_d = 1'b0;
                    freezing_d    = 1'b0;
                    aeoi_hit      = aeoi & ~spurious_q;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clears land before the set, so a bit set this cycle survives an EOI on it.
        aeoi_mask = aeoi_hit ? (8'd1 << cur_idx_q) : 8'd0;
        isr_d     = (isr_q & ~eoi_clr & ~aeoi_mask) | set_mask;
        if (eoi_hit)
            reseted_d = eoi_idx;
        else if (aeoi_hit)
            reseted_d = cur_idx_q;
        else
            reseted_d = reseted_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            inta_hist_q       <= 1'b1;
            int_out_q         <= 1'b0;
            ack_q             <= 1'b0;
            freezing_q        <= 1'b0;
            isr_q             <= 8'd0;
            irr_clear_q       <= 1'b0;
            irr_clear_index_q <= 3'd0;
            reseted_q         <= 3'd0;
            data_out_q        <= 8'd0;
            data_out_en_q     <= 1'b0;
            cur_idx_q         <= 3'd0;
            spurious_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            inta_hist_q       <= inta_n;
            int_out_q         <= int_out_d;
            ack_q             <= ack_d;
            freezing_q        <= freezing_d;
            isr_q             <= isr_d;
            irr_clear_q       <= irr_clear_d;
            irr_clear_index_q <= irr_clear_index_d;
            reseted_q         <= reseted_d;
            data_out_q        <= data_out_d;
            data_out_en_q     <= data_out_en_d;
            cur_idx_q         <= cur_idx_d;
            spurious_q        <= spurious_d;
        end
    end

    assign int_out           = int_out_q;
    assign int_request_ack   = ack_q;
    assign freezing          = freezing_q;
    assign isr_reg           = isr_q;
    assign irr_clear         = irr_clear_q;
    assign irr_clear_index   = irr_clear_index_q;
    assign reseted_isr_index = reseted_q;
    assign data_out          = data_out_q;
    assign data_out_en       = data_out_en_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Bench for pic_ack_sequencer: directed scenarios plus randomized acknowledge/EOI traffic
// scored against a transaction-level ISR model.
module tb_pic_ack_sequencer;

    logic       clk;
    logic       reset;
    logic       int_request;
    logic [2:0] serviced_interrupt_index;
    logic [2:0] zero_level_priority_bit;
    logic       inta_n;
    logic [4:0] icw2_vector_base;
    logic       aeoi;
    logic [7:0] ocw2;
    logic       ocw2_write;
    logic       int_out;
    logic       int_request_ack;
    logic       freezing;
    logic [7:0] isr_reg;
    logic       irr_clear;
    logic [2:0] irr_clear_index;
    logic [2:0] reseted_isr_index;
    logic [7:0] data_out;
    logic       data_out_en;

    int checks;
    int failures;

    logic [7:0] m_isr;
    logic [2:0] m_res;
    logic       m_ack;

    pic_ack_sequencer dut (
        .clk                      (clk),
        .reset                    (reset),
        .int_request              (int_request),
        .serviced_interrupt_index (serviced_interrupt_index),
        .zero_level_priority_bit  (zero_level_priority_bit),
        .inta_n                   (inta_n),
        .icw2_vector_base         (icw2_vector_base),
        .aeoi                     (aeoi),
        .ocw2                     (ocw2),
        .ocw2_write               (ocw2_write),
        .int_out                  (int_out),
        .int_request_ack          (int_request_ack),
        .freezing                 (freezing),
        .isr_reg                  (isr_reg),
        .irr_clear                (irr_clear),
        .irr_clear_index          (irr_clear_index),
        .reseted_isr_index        (reseted_isr_index),
        .data_out                 (data_out),
        .data_out_en              (data_out_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {hit, index, clear_mask} for an OCW2 write against a given ISR.
    function automatic logic [11:0] eoi_eval(input logic [7:0] isr, input logic [7:0] w,
                                             input logic [2:0] z);
        logic [2:0] j;
        eoi_eval = 12'd0;
        if (w[7:5] == 3'b011) begin
            eoi_eval = {1'b1, w[2:0], 8'd1 << w[2:0]};
        end else if (w[7:5] == 3'b001 || w[7:5] == 3'b101) begin
            for (int i = 7; i >= 0; i--) begin
                j = 3'((32'(z) + 32'(i)) % 8);
                if (isr[j]) eoi_eval = {1'b1, j, 8'd1 << j};
            end
        end
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        int_request = 1'b0;
        inta_n      = 1'b1;
        ocw2_write  = 1'b0;
        tick();
        chk("rst_int_out", 32'(int_out), 32'd0);
        chk("rst_ack", 32'(int_request_ack), 32'd0);
        chk("rst_freezing", 32'(freezing), 32'd0);
        chk("rst_isr", 32'(isr_reg), 32'd0);
        chk("rst_irr_clear", 32'(irr_clear), 32'd0);
        chk("rst_irr_idx", 32'(irr_clear_index), 32'd0);
        chk("rst_reseted", 32'(reseted_isr_index), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_en", 32'(data_out_en), 32'd0);
        reset = 1'b0;
        m_isr = 8'd0;
        m_res = 3'd0;
        m_ack = 1'b0;
    endtask

    task automatic eoi(input logic [7:0] v, input logic [2:0] z);
        logic [11:0] e;
        ocw2 = v;
        zero_level_priority_bit = z;
        ocw2_write = 1'b1;
        e = eoi_eval(m_isr, v, z);
        m_isr = m_isr & ~e[7:0];
        if (e[11]) m_res = e[10:8];
        tick();
        ocw2_write = 1'b0;
        chk("eoi_isr", 32'(isr_reg), 32'(m_isr));
        chk("eoi_reseted", 32'(reseted_isr_index), 32'(m_res));
    endtask

    // eoi_at: 0 none, 1 with the first INTA fall, 2 with the second INTA rise.
    task automatic run_ack(input logic [2:0] idx, input logic [4:0] base, input logic aeoi_v,
                           input logic spur, input int eoi_at, input logic [7:0] eoi_v,
                           input logic [2:0] z, input int pend);
        logic [11:0] e;
        logic [7:0]  setm;
        logic [7:0]  clr;
        logic [2:0]  vidx;
        vidx = spur ? 3'd7 : idx;
        setm = spur ? 8'd0 : (8'd1 << idx);
        int_request = 1'b1;
        serviced_interrupt_index = idx;
        icw2_vector_base = base;
        aeoi = aeoi_v;
        zero_level_priority_bit = z;
        tick();
        chk("int_out_rise", 32'(int_out), 32'd1);
        if (spur) int_request = 1'b0;
        for (int k = 0; k < pend; k++) begin
            tick();
            chk("int_out_hold", 32'(int_out), 32'd1);
            chk("no_early_freeze", 32'(freezing), 32'd0);
        end

        inta_n = 1'b0;
        if (eoi_at == 1) begin
            ocw2 = eoi_v;
            ocw2_write = 1'b1;
            e = eoi_eval(m_isr, eoi_v, z);
            m_isr = (m_isr & ~e[7:0]) | setm;
            if (e[11]) m_res = e[10:8];
        end else begin
            m_isr = m_isr | setm;
        end
        if (!spur) m_ack = ~m_ack;
        tick();
        ocw2_write = 1'b0;
        chk("ack1_freezing", 32'(freezing), 32'd1);
        chk("ack1_irr_clear", 32'(irr_clear), spur ? 32'd0 : 32'd1);
        if (!spur) chk("ack1_irr_idx", 32'(irr_clear_index), 32'(idx));
        chk("ack1_toggle", 32'(int_request_ack), 32'(m_ack));
        chk("ack1_isr", 32'(isr_reg), 32'(m_isr));
        chk("ack1_reseted", 32'(reseted_isr_index), 32'(m_res));

        int_request = 1'b0;
        tick();
        chk("irr_clear_once", 32'(irr_clear), 32'd0);
        chk("ack1_int_held", 32'(int_out), 32'd1);

        inta_n = 1'b1;
        tick();
        chk("int_out_drop", 32'(int_out), 32'd0);
        chk("wait2_freezing", 32'(freezing), 32'd1);
        tick();
        inta_n = 1'b0;
        tick();
        chk("vector", 32'(data_out), 32'({base, vidx}));
        chk("data_en_on", 32'(data_out_en), 32'd1);

        inta_n = 1'b1;
        clr = 8'd0;
        e = 12'd0;
        if (eoi_at == 2) begin
            ocw2 = eoi_v;
            ocw2_write = 1'b1;
            e = eoi_eval(m_isr, eoi_v, z);
            clr = e[7:0];
        end
        if (aeoi_v && !spur) clr = clr | (8'd1 << idx);
        m_isr = m_isr & ~clr;
        if (e[11]) m_res = e[10:8];
        else if (aeoi_v && !spur) m_res = idx;
        tick();
        ocw2_write = 1'b0;
        chk("data_en_off", 32'(data_out_en), 32'd0);
        chk("freeze_off", 32'(freezing), 32'd0);
        chk("end_isr", 32'(isr_reg), 32'(m_isr));
        chk("end_reseted", 32'(reseted_isr_index), 32'(m_res));
        chk("end_toggle", 32'(int_request_ack), 32'(m_ack));
    endtask

    initial begin
        logic [7:0] codes [5];
        logic [7:0] ev;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        int_request = 1'b0;
        serviced_interrupt_index = 3'd0;
        zero_level_priority_bit = 3'd0;
        inta_n = 1'b1;
        icw2_vector_base = 5'd0;
        aeoi = 1'b0;
        ocw2 = 8'd0;
        ocw2_write = 1'b0;
        codes[0] = 8'h20; codes[1] = 8'hA0; codes[2] = 8'h60; codes[3] = 8'h40; codes[4] = 8'h00;

        do_reset();

        // Basic acknowledge then automatic EOI of the same index.
        run_ack(3'd3, 5'b01000, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        chk("basic_isr", 32'(isr_reg), 32'h08);
        run_ack(3'd3, 5'b01000, 1'b1, 1'b0, 0, 8'h00, 3'd0, 1);
        chk("aeoi_isr", 32'(isr_reg), 32'h00);
        chk("aeoi_reseted", 32'(reseted_isr_index), 32'd3);

        // Non-specific EOI with rotation.
        run_ack(3'd1, 5'b00001, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        run_ack(3'd5, 5'b00001, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        eoi(8'h20, 3'd4);
        chk("nseoi_isr", 32'(isr_reg), 32'h02);
        chk("nseoi_idx", 32'(reseted_isr_index), 32'd5);

        // Specific EOI.
        do_reset();
        run_ack(3'd7, 5'b00010, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        run_ack(3'd0, 5'b00010, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        eoi(8'h67, 3'd0);
        chk("seoi_isr", 32'(isr_reg), 32'h01);
        chk("seoi_idx", 32'(reseted_isr_index), 32'd7);
        eoi(8'h20, 3'd3);
        eoi(8'h20, 3'd3);

        // Spurious acknowledge.
        run_ack(3'd2, 5'b10000, 1'b1, 1'b1, 0, 8'h00, 3'd0, 1);
        chk("spur_vector", 32'(data_out), 32'h87);

        // Set and EOI of the same bit together; AEOI and EOI together.
        run_ack(3'd4, 5'b00100, 1'b0, 1'b0, 1, 8'h64, 3'd0, 0);
        chk("set_survives", 32'(isr_reg[4]), 32'd1);
        run_ack(3'd6, 5'b00100, 1'b1, 1'b0, 2, 8'h20, 3'd0, 0);
        chk("both_cleared", 32'(isr_reg), 32'h00);
        chk("eoi_idx_wins", 32'(reseted_isr_index), 32'd4);

        // Reset during WAIT2, then a fresh sequence.
        int_request = 1'b1;
        serviced_interrupt_index = 3'd2;
        tick();
        inta_n = 1'b0;
        tick();
        int_request = 1'b0;
        inta_n = 1'b1;
        tick();
        do_reset();
        run_ack(3'd6, 5'b11111, 1'b0, 1'b0, 0, 8'h00, 3'd0, 0);
        chk("post_reset_isr", 32'(isr_reg), 32'h40);

        for (int t = 0; t < 30; t++) begin
            ev = codes[$urandom_range(0, 4)] | 8'($urandom_range(0, 7));
            run_ack(3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)), ev,
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0)
                eoi(codes[$urandom_range(0, 4)] | 8'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
